dispatch_arbiter: RTL and testbench

Clocked, parameterised instruction dispatcher for the multicore processor. It accepts one 32-bit instruction per cycle over a valid/ready handshake and routes it to one of NUM_CORES per-core instruction FIFOs. Each core keeps a retire-tracked history of its in-flight instructions, and routing uses register-tag dependency checks against every other core's history. It sits between the instruction fetch stream and the per-core FIFOs.

---
 rtl/dispatch_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dispatch_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_arbiter.sv
// Instruction dispatcher: routes one instruction per cycle to one of NUM_CORES FIFOs,
// steering dependent instructions to the core whose in-flight history they conflict with.
module dispatch_arbiter #(
  parameter int NUM_CORES  = 2,
  parameter int DATA_W     = 32,
  parameter int HIST_DEPTH = 8,
  localparam int CORE_W    = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DATA_W-1:0]    in_instr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_CORES-1:0] fifo_ready,
  output logic [DATA_W-1:0]    out_instr,
  output logic [NUM_CORES-1:0] out_valid,
  input  logic [NUM_CORES-1:0] retire,
  output logic                 stall
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NCF_W = CORE_W + 1;

  typedef logic [6:0] tag_t;

  typedef struct packed {
    tag_t src;
    tag_t dst;
  } hist_entry_t;

  function automatic tag_t src_tag(input logic [DATA_W-1:0] i);
    return {i[23], i[10], (i[10] ? i[9:5] : i[4:0])};
  endfunction

  function automatic tag_t dst_tag(input logic [DATA_W-1:0] i);
    return {i[22], i[21], (i[21] ? i[20:16] : i[15:11])};
  endfunction

  // Entry idx is live when its distance from the oldest entry is below the count.
  function automatic logic in_window(input logic [PTR_W-1:0] idx,
                                     input logic [PTR_W-1:0] rd,
                                     input logic [CNT_W-1:0] cnt);
    logic [PTR_W-1:0] off;
    off = idx - rd;
    return {1'b0, off} < cnt;
  endfunction

  hist_entry_t       hist   [NUM_CORES][HIST_DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CORES];
  logic [PTR_W-1:0]  wr_ptr [NUM_CORES];
  logic [CNT_W-1:0]  count  [NUM_CORES];
  logic [CORE_W-1:0] rr_ptr;

  tag_t                  new_src;
  tag_t                  new_dst;
  logic                  pinned;
  logic                  exempt;
  logic [NUM_CORES-1:0]  conflict;
  logic [NCF_W-1:0]      num_conf;
  logic [CORE_W-1:0]     conf_core;
  logic [CORE_W-1:0]     target;
  logic                  target_ok;
  logic                  room;
  logic                  slot_ok;
  logic                  accept;
  logic [NUM_CORES-1:0]  push;
  logic [NUM_CORES-1:0]  pop;

  assign new_src = src_tag(in_instr);
  assign new_dst = dst_tag(in_instr);
  assign pinned  = in_instr[28];
  assign exempt  = in_instr[23] & in_instr[22];

  // RAW, WAR and WAW against every live entry of every core.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    conflict  = '0;
    num_conf  = '0;
    conf_core = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int p = 0; p < HIST_DEPTH; p++) begin
        if (in_window(PTR_W'(p), rd_ptr[c], count[c]) &&
            ((new_src == hist[c][p].dst) ||
             (new_dst == hist[c][p].src) ||
             (new_dst == hist[c][p].dst))) begin
          conflict[c] = 1'b1;
        end
      end
      if (conflict[c]) begin
        num_conf  = num_conf + NCF_W'(1);
        conf_core = CORE_W'(c);
      end
    end
  end

  always_comb begin
    target    = rr_ptr;
    target_ok = 1'b1;
    if (pinned) begin
      target = in_instr[27 -: CORE_W];
    end else if (exempt) begin
      target = rr_ptr;
    end else if (num_conf == NCF_W'(1)) begin
      target = conf_core;
    end else if (num_conf > NCF_W'(1)) begin
      target_ok = 1'b0;
    end
  end

  assign room     = count[target] < CNT_W'(HIST_DEPTH);
  assign slot_ok  = (out_valid == '0) || (|(out_valid & fifo_ready));
  assign in_ready = resetn && target_ok && room && slot_ok;
  assign accept   = in_valid && in_ready;
  assign stall    = resetn && in_valid && !in_ready;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      push[c] = accept && (target == CORE_W'(c));
      pop[c]  = retire[c] && (count[c] != '0);
    end
  end

  // Output slot: reloads on accept, otherwise clears once the selected FIFO takes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= '0;
      out_instr <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= NUM_CORES'(1) << target;
      out_instr <= in_instr;
      rr_ptr    <= target + 1'b1;
    end else if (|(out_valid & fifo_ready)) begin
      out_valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
        else if (pop[c] && !push[c]) count[c] <= count[c] - 1'b1;
      end
    end
  end

  // NOTE: tag storage has no reset; count gates which entries are live, so stale contents are harmless.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORES; c++) begin
      if (push[c]) hist[c][wr_ptr[c]] <= '{src: new_src, dst: new_dst};
    end
  end

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Directed bench for dispatch_arbiter: a scoreboard queue holds expected FIFO writes,
// a monitor compares every completed write; handshake and stall behaviour is checked inline.
module tb_dispatch_arbiter;

  localparam int NC = 2;
  localparam logic [31:0] EXEMPT = 32'h00C0_0000;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   in_instr;
  logic          in_valid;
  logic          in_ready;
  logic [NC-1:0] fifo_ready;
  logic [31:0]   out_instr;
  logic [NC-1:0] out_valid;
  logic [NC-1:0] retire;
  logic          stall;

  typedef struct packed {
    logic [NC-1:0] valid;
    logic [31:0]   instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dispatch_arbiter #(.NUM_CORES(NC), .DATA_W(32), .HIST_DEPTH(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_instr   (in_instr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fifo_ready (fifo_ready),
    .out_instr  (out_instr),
    .out_valid  (out_valid),
    .retire     (retire),
    .stall      (stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A write completes on the edge following a negedge where out_valid meets fifo_ready.
  always @(negedge clk) begin
    if (resetn === 1'b1 && (out_valid & fifo_ready) != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got valid=0x%0h instr=0x%0h expected none", out_valid, out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_valid", 32'(out_valid), 32'(mon_e.valid));
        check("write_instr", out_instr, mon_e.instr);
      end
    end
  end

  task automatic drive_one(input logic [31:0] instr, input int core);
    in_instr = instr;
    in_valid = 1'b1;
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{valid: NC'(1 << core), instr: instr});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    wait_drain();
    @(posedge clk);
    #1;
    resetn   = 1'b0;
    in_valid = 1'b0;
    retire   = '0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn     = 1'b0;
    in_valid   = 1'b1;
    in_instr   = EXEMPT;
    fifo_ready = '1;
    retire     = '0;

    // Reset with a request pending, then exempt instructions alternate cores.
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_instr = EXEMPT | 32'(k);
      in_valid = 1'b1;
      @(negedge clk);
      check("rr_ready", 32'(in_ready), 32'd1);
      if (k > 0) check("rr_latency", 32'(out_valid), 32'(1 << ((k - 1) % 2)));
      exp_q.push_back('{valid: NC'(1 << (k % 2)), instr: EXEMPT | 32'(k)});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rr_last_valid", 32'(out_valid), 32'h2);

    // Retire at empty history is ignored; pinned goes to core 1, round-robin restarts at 0.
    apply_reset();
    retire = '1;
    @(posedge clk);
    #1;
    retire = '0;
    drive_one(32'h1800_0000, 1);
    drive_one(EXEMPT | 32'h11, 0);

    // RAW steers to core 1; a follow-up dependent on that instruction also goes to core 1.
    apply_reset();
    drive_one(32'h1800_1800, 1);
    drive_one(32'h0025_0003, 1);
    drive_one(32'h0028_04A0, 1);

    // Conflicts on two cores stall until core 1 retires; same-cycle retire does not unblock.
    apply_reset();
    drive_one(32'h1000_0804, 0);
    drive_one(32'h1800_1005, 1);
    in_instr = 32'h0000_1001;
    in_valid = 1'b1;
    @(negedge clk);
    check("multi_stall", 32'(stall), 32'd1);
    check("multi_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    retire = 2'b10;
    @(negedge clk);
    check("multi_same_cycle_retire", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    retire = '0;
    drive_one(32'h0000_1001, 0);

    // Backpressure holds the slot; releasing it reloads with no bubble.
    apply_reset();
    fifo_ready = '0;
    drive_one(EXEMPT | 32'hAA, 0);
    in_instr = EXEMPT | 32'hBB;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_stall", 32'(stall), 32'd1);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_instr", out_instr, EXEMPT | 32'hAA);
      @(posedge clk);
      #1;
    end
    fifo_ready = '1;
    drive_one(EXEMPT | 32'hBB, 1);
    check("bp_no_bubble", 32'(out_valid), 32'h2);
    drive_one(EXEMPT | 32'hCC, 0);

    // History full: 8 pinned to core 0, then stall; retire+push keeps the count.
    apply_reset();
    for (int k = 0; k < 8; k++) drive_one(32'h1000_0000 | 32'(k), 0);
    in_instr = 32'h1000_0008;
    in_valid = 1'b1;
    @(negedge clk);
    check("full_stall", 32'(stall), 32'd1);
    check("full_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    retire = 2'b01;
    @(negedge clk);
    check("full_same_cycle_retire", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    drive_one(32'h1000_0008, 0);
    retire = '0;
    drive_one(32'h1000_0009, 0);
    in_instr = 32'h1000_000A;
    in_valid = 1'b1;
    @(negedge clk);
    check("full_again_stall", 32'(stall), 32'd1);
    check("full_again_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Reset mid-transfer drops the pending output.
    apply_reset();
    fifo_ready = '0;
    drive_one(EXEMPT | 32'h55, 0);
    check("mid_pending", 32'(out_valid), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_reset_valid", 32'(out_valid), 32'd0);
    check("mid_reset_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn     = 1'b1;
    fifo_ready = '1;
    @(negedge clk);
    check("mid_after_valid", 32'(out_valid), 32'd0);
    drive_one(EXEMPT | 32'h66, 0);

    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
